bram_port_arbiter: RTL and testbench
====================================

# bram_port_arbiter

Round-robin arbiter sharing port A of one `true_dpbram` instance between two requesters. Typical pairing: requester 0 is a host/DMA loader filling node/weight/bias memories; requester 1 is the data mover reading them. Each requester asks for a burst of N accesses. The arbiter grants exclusive use of the port, counts beats, drains the one-cycle BRAM read latency, then releases. It sits between the requesters' memory interfaces and the BRAM's addr/ce/we/d/q port.

## Interface
- `DWIDTH`, default 32, BRAM data width.
- `AWIDTH`, default 12, BRAM address width.
- `MEM_SIZE`, default 4096, BRAM depth; the maximum legal burst length.
- `clk`, in, 1, clock.
- `reset_n`, in, 1, reset. One clock; reset is asynchronous and active-low.
- `rX_req` (X=0,1), in, 1, burst request level. Held until `rX_done`.
- `rX_len`, in, AWIDTH+1, burst length in beats, 0..MEM_SIZE. Sampled at grant.
- `rX_addr`, in, AWIDTH, requester address.
- `rX_ce`, in, 1, requester chip enable.
- `rX_we`, in, 1, requester write enable.
- `rX_d`, in, DWIDTH, requester write data.
- `rX_gnt`, out, 1, port owned by requester X (registered).
- `rX_q`, out, DWIDTH, BRAM read data, broadcast unmodified to both requesters.
- `rX_q_valid`, out, 1, rX_q holds data for a read beat that X issued in the previous cycle.
- `rX_done`, out, 1, one-cycle pulse: burst finished or aborted.
- `addr`, out, AWIDTH, BRAM port-A address.
- `ce`, out, 1, BRAM port-A chip enable.
- `we`, out, 1, BRAM port-A write enable.
- `d`, out, DWIDTH, BRAM port-A write data.
- `q`, in, DWIDTH, BRAM port-A read data.
- `o_busy`, out, 1, high in any state other than IDLE.

## Operation
- FSM states: IDLE, GRANT0, GRANT1, DRAIN.
- IDLE → GRANTx:
  - Only one requester asserts req: grant it.
  - Both assert req: grant the one not served last.
  - Last-served pointer resets to 1, so requester 0 wins the first tie.
  - On entry, load the beat counter with `rX_len` and update the pointer to X.
- GRANTx:
  - BRAM addr/ce/we/d come combinationally from requester X.
  - Every cycle with `rX_ce`=1 is a beat and decrements the counter.
  - The beat that takes the counter to 0 is the last beat; next state is DRAIN.
- `rX_len`=0: GRANTx lasts exactly one cycle with BRAM `ce`/`we` forced to 0, then DRAIN. No beats are issued.
- Abort: `rX_req` low while in GRANTx:
  - BRAM ce/we are forced to 0 in that cycle.
  - Next state is DRAIN. `done` still pulses.
- DRAIN:
  - Lasts one cycle with BRAM ce/we forced to 0.
  - `rX_done` is high for this cycle.
  - Next state is IDLE.
- Non-granted requester: its ce/we have no effect on the BRAM. Its `gnt`, `q_valid` and `done` stay 0.
- Outside GRANTx: BRAM addr=0, d=0, ce=0, we=0.
- `rX_q_valid` is a register set to (granted beat from X with we=0). It stays valid in DRAIN for the last beat.
- `ce`=1 with `we`=1 is a write beat. It counts as a beat and never raises `q_valid`.
- Ce pulses beyond `len` in GRANTx cannot occur, because the FSM leaves GRANTx on the last beat.
- Reset, including mid-burst:
  - State returns to IDLE, counter to 0, pointer to 1.
  - All `gnt`, `q_valid`, `done` and `o_busy` go to 0.
  - BRAM ce/we go to 0 immediately (asynchronous).
  - Any interrupted burst produces no `done`.

## Timing
- Reset values: all `rX_gnt`, `rX_q_valid`, `rX_done`, `o_busy`, `ce` and `we` are 0. `addr` and `d` are 0.
- Request to grant:
  - `rX_req` high in an IDLE cycle T → `rX_gnt` high from T+1.
  - The first beat may be issued in cycle T+1.
- Read latency: a beat at cycle B → `rX_q` is valid with `rX_q_valid`=1 at B+1.
- Burst of N beats issued back-to-back from T+1:
  - Last beat at T+N.
  - DRAIN and `done` at T+N+1.
  - IDLE at T+N+2.
  - Earliest next grant at T+N+3.
- Grant-to-grant overhead: 2 dead cycles (DRAIN, IDLE).
- Beats may have gaps (`ce`=0 cycles). Gap cycles do not decrement the counter.
- `gnt` falls in the DRAIN cycle. The requester must not drive `ce` after its last beat.

## Test plan
- Single write burst:
  - Stimulus: r0 req, len=4, writes 0xA..0xD to addr 0..3, then r1 reads addr 0..3, len=4.
  - Response: r1_q_valid for 4 cycles, data 0xA..0xD; each done pulses once; o_busy low at the end.
- Tie and round-robin:
  - Stimulus: both req from reset with len=2, repeated 3 rounds.
  - Response: grant order r0, r1, r0, r1, r0, r1; never both gnt high.
- Lockout:
  - Stimulus: r1 drives ce=1, we=1 to addr 5 while r0 holds grant.
  - Response: BRAM addr 5 unchanged; r1_q_valid stays 0.
- Zero length and gapped beats:
  - Stimulus: r0 len=0, then r0 len=3 with ce pattern 1,0,1,0,1.
  - Response: first burst has 1-cycle gnt, no BRAM ce, done pulse. Second burst has exactly 3 BRAM ce, then DRAIN.
- Abort:
  - Stimulus: r1 len=8, req dropped after 3 beats.
  - Response: BRAM ce low in the drop cycle; r1_done pulses the next cycle; a pending r0 is granted 2 cycles after that.
- Reset mid-burst:
  - Stimulus: assert reset_n=0 during beat 2 of an r0 len=6 burst, then both req.
  - Response: ce/gnt drop immediately; no done; r0 granted first after release.

Source files
------------

// File: rtl/bram_port_arbiter_if.sv
// One requester's side of the shared BRAM port: burst request, memory access and grant/response.
interface bram_port_arbiter_if #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 12
);
  localparam int unsigned LW = AWIDTH + 1;

  logic              req;
  logic [LW-1:0]     len;
  logic [AWIDTH-1:0] addr;
  logic              ce;
  logic              we;
  logic [DWIDTH-1:0] d;
  logic              gnt;
  logic [DWIDTH-1:0] q;
  logic              q_valid;
  logic              done;

  modport master (
    output req, len, addr, ce, we, d,
    input  gnt, q, q_valid, done
  );

  modport slave (
    input  req, len, addr, ce, we, d,
    output gnt, q, q_valid, done
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter giving two requesters exclusive burst access to BRAM port A,
// with beat counting, abort handling and a one-cycle read-latency drain.
module bram_port_arbiter #(
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned AWIDTH   = 12,
  parameter int unsigned MEM_SIZE = 4096
) (
  input  logic                 clk,
  input  logic                 reset_n,
  bram_port_arbiter_if.slave   r0,
  bram_port_arbiter_if.slave   r1,
  output logic [AWIDTH-1:0]    addr,
  output logic                 ce,
  output logic                 we,
  output logic [DWIDTH-1:0]    d,
  input  logic [DWIDTH-1:0]    q,
  output logic                 o_busy
);

  localparam int unsigned LW = AWIDTH + 1;
  localparam logic [LW-1:0] MAX_LEN = LW'(MEM_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_GRANT0, S_GRANT1, S_DRAIN} state_t;

  state_t        r_state, w_next;
  logic [LW-1:0] r_cnt, w_cnt_nxt;
  logic          r_last, w_last_nxt;
  logic [1:0]    r_gnt, w_gnt_nxt;
  logic [1:0]    r_qv, w_qv_nxt;
  logic [1:0]    r_done, w_done_nxt;
  logic          r_busy;

  logic              w_grant, w_sel, w_req, w_ce, w_we, w_live, w_beat;
  logic [AWIDTH-1:0] w_addr;
  logic [DWIDTH-1:0] w_d;
  logic [LW-1:0]     w_len0, w_len1;

  // Requester mux: only the owner's signals ever reach the BRAM
  assign w_grant = (r_state == S_GRANT0) || (r_state == S_GRANT1);
  assign w_sel   = (r_state == S_GRANT1);
  assign w_req   = w_sel ? r1.req  : r0.req;
  assign w_ce    = w_sel ? r1.ce   : r0.ce;
  assign w_we    = w_sel ? r1.we   : r0.we;
  assign w_addr  = w_sel ? r1.addr : r0.addr;
  assign w_d     = w_sel ? r1.d    : r0.d;

  // Live: owner still requesting with beats remaining; zero-length and abort cycles are dead
  assign w_live = w_grant && w_req && (r_cnt != '0);
  assign w_beat = w_live && w_ce;

  // Oversized lengths saturate at the memory depth
  assign w_len0 = (r0.len > MAX_LEN) ? MAX_LEN : r0.len;
  assign w_len1 = (r1.len > MAX_LEN) ? MAX_LEN : r1.len;

  assign addr = w_grant ? w_addr : '0;
  assign d    = w_grant ? w_d    : '0;
  assign ce   = w_beat;
  assign we   = w_beat && w_we;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_gnt   <= '0;
      r_qv    <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
      r_gnt   <= w_gnt_nxt;
      r_qv    <= w_qv_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= (w_next != S_IDLE);
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_nxt  = r_cnt;
    w_last_nxt = r_last;
    w_gnt_nxt  = '0;
    w_qv_nxt   = '0;
    w_done_nxt = '0;
    unique case (r_state)
      S_IDLE: begin
        // Tie goes to whichever requester was not served last
        if (r0.req && (!r1.req || r_last)) begin
          w_next       = S_GRANT0;
          w_cnt_nxt    = w_len0;
          w_last_nxt   = 1'b0;
          w_gnt_nxt[0] = 1'b1;
        end else if (r1.req) begin
          w_next       = S_GRANT1;
          w_cnt_nxt    = w_len1;
          w_last_nxt   = 1'b1;
          w_gnt_nxt[1] = 1'b1;
        end
      end
      S_GRANT0, S_GRANT1: begin
        if (w_beat) begin
          w_cnt_nxt = r_cnt - LW'(1);
        end
        w_qv_nxt[w_sel] = w_beat && !w_we;
        if (!w_live || (w_beat && (r_cnt == LW'(1)))) begin
          w_next            = S_DRAIN;
          w_done_nxt[w_sel] = 1'b1;
        end else begin
          w_gnt_nxt[w_sel] = 1'b1;
        end
      end
      S_DRAIN: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign r0.gnt     = r_gnt[0];
  assign r1.gnt     = r_gnt[1];
  assign r0.q       = q;
  assign r1.q       = q;
  assign r0.q_valid = r_qv[0];
  assign r1.q_valid = r_qv[1];
  assign r0.done    = r_done[0];
  assign r1.done    = r_done[1];
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a small behavioural BRAM on port A.
module tb_bram_port_arbiter;

  localparam int unsigned DWIDTH = 32;
  localparam int unsigned AWIDTH = 12;

  logic              clk;
  logic              reset_n;
  logic [AWIDTH-1:0] addr;
  logic              ce, we;
  logic [DWIDTH-1:0] d, q;
  logic              busy;

  logic [DWIDTH-1:0] mem [0:63];

  int n_cmp = 0;
  int n_err = 0;

  bram_port_arbiter_if #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_r0 ();
  bram_port_arbiter_if #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_r1 ();

  bram_port_arbiter #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .MEM_SIZE(4096)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .r0      (u_r0),
    .r1      (u_r1),
    .addr    (addr),
    .ce      (ce),
    .we      (we),
    .d       (d),
    .q       (q),
    .o_busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port view of the BRAM: write-or-read, one-cycle read latency
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h100 + 32'(i);
      q <= '0;
    end else if (ce) begin
      if (we) mem[addr[5:0]] <= d;
      else    q <= mem[addr[5:0]];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    u_r0.req = 0; u_r0.len = '0; u_r0.addr = '0; u_r0.ce = 0; u_r0.we = 0; u_r0.d = '0;
    u_r1.req = 0; u_r1.len = '0; u_r1.addr = '0; u_r1.ce = 0; u_r1.we = 0; u_r1.d = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt",  64'({u_r0.gnt, u_r1.gnt}), 64'd0);
    check("rst_qv",   64'({u_r0.q_valid, u_r1.q_valid}), 64'd0);
    check("rst_done", 64'({u_r0.done, u_r1.done}), 64'd0);
    check("rst_port", 64'({busy, ce, we}), 64'd0);
    check("rst_ad",   64'({addr, d}), 64'd0);
    reset_n = 1'b1;
  endtask

  // Bounded wait for a grant; 0/1 = owner, 2 = both granted, -1 = none in time
  task automatic wait_gnt(output int who);
    who = -1;
    for (int k = 0; k < 8 && who < 0; k++) begin
      step();
      @(negedge clk);
      if (u_r0.gnt && u_r1.gnt) who = 2;
      else if (u_r0.gnt)        who = 0;
      else if (u_r1.gnt)        who = 1;
    end
  endtask

  task automatic drive_ce(input int who, input logic v);
    if (who == 0) u_r0.ce = v; else u_r1.ce = v;
  endtask

  initial begin
    int         who;
    int         nce;
    logic [4:0] pat;
    reset_n = 1'b0;
    do_reset();

    // Single write burst from r0, then read back by r1
    step(); u_r0.req = 1; u_r0.len = 13'd4;
    for (int i = 0; i < 4; i++) begin
      step(); u_r0.ce = 1; u_r0.we = 1; u_r0.addr = 12'(i); u_r0.d = 32'hA + 32'(i);
      @(negedge clk);
      check("wr_gnt", 64'(u_r0.gnt), 64'd1);
      check("wr_ce",  64'({ce, we}), 64'd3);
    end
    step(); u_r0.ce = 0; u_r0.we = 0; u_r0.req = 0;
    @(negedge clk);
    check("wr_done", 64'({u_r0.done, u_r0.gnt, ce, busy}), 64'b1001);
    step(); u_r1.req = 1; u_r1.len = 13'd4;
    @(negedge clk);
    check("wr_idle", 64'({busy, u_r0.done}), 64'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      if (i < 4) begin u_r1.ce = 1; u_r1.we = 0; u_r1.addr = 12'(i); end
      else begin u_r1.ce = 0; u_r1.req = 0; end
      @(negedge clk);
      if (i == 0) check("rd_gnt", 64'(u_r1.gnt), 64'd1);
      if (i > 0) begin
        check("rd_qv", 64'({u_r1.q_valid, u_r0.q_valid}), 64'b10);
        check("rd_q",  64'(u_r1.q), 64'(32'hA + 32'(i - 1)));
      end
    end
    check("rd_done", 64'({u_r1.done, ce}), 64'b10);
    step();
    @(negedge clk);
    check("rd_end", 64'({busy, u_r1.q_valid, u_r1.done}), 64'd0);

    // Tie from reset alternates r0, r1, ...
    do_reset();
    step(); u_r0.req = 1; u_r0.len = 13'd2; u_r1.req = 1; u_r1.len = 13'd2;
    for (int g = 0; g < 6; g++) begin
      wait_gnt(who);
      check("rr_owner", 64'(who), 64'(g % 2));
      if (who < 0 || who > 1) who = g % 2;
      for (int b = 0; b < 2; b++) begin
        step(); drive_ce(who, 1'b1);
        @(negedge clk);
        check("rr_excl", 64'({u_r0.gnt, u_r1.gnt}), (who == 0) ? 64'b10 : 64'b01);
      end
      step(); drive_ce(who, 1'b0);
      @(negedge clk);
      check("rr_done", 64'({u_r0.done, u_r1.done}), (who == 0) ? 64'b10 : 64'b01);
    end
    step(); idle_inputs();

    // Lockout: r1 writes without a grant while r0 reads addr 5
    step(); u_r0.req = 1; u_r0.len = 13'd2;
    u_r1.ce = 1; u_r1.we = 1; u_r1.addr = 12'd5; u_r1.d = 32'hDEAD;
    @(negedge clk);
    check("lk_idle_ce", 64'(ce), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      u_r0.ce = (i < 2); u_r0.we = 0; u_r0.addr = 12'd5;
      if (i == 2) u_r0.req = 0;
      @(negedge clk);
      check("lk_we", 64'(we), 64'd0);
      check("lk_qv1", 64'(u_r1.q_valid), 64'd0);
      if (i > 0) check("lk_q", 64'({u_r0.q_valid, u_r0.q}), {31'd0, 1'b1, 32'h105});
    end
    check("lk_done", 64'(u_r0.done), 64'd1);
    check("lk_mem", 64'(mem[5]), 64'h105);
    step(); idle_inputs();

    // Zero length: one grant cycle, no BRAM access, done
    step(); u_r0.req = 1; u_r0.len = 13'd0;
    step(); u_r0.ce = 1; u_r0.we = 1; u_r0.addr = 12'd9;
    @(negedge clk);
    check("z_gnt", 64'({u_r0.gnt, ce, we}), 64'b100);
    step(); u_r0.ce = 0; u_r0.we = 0; u_r0.req = 0;
    @(negedge clk);
    check("z_done", 64'({u_r0.done, u_r0.gnt}), 64'b10);

    // Gapped beats: pattern 1,0,1,0,1 for len 3
    step(); u_r0.req = 1; u_r0.len = 13'd3;
    pat = 5'b10101;
    nce = 0;
    for (int k = 0; k < 5; k++) begin
      step(); u_r0.ce = pat[k]; u_r0.we = 1; u_r0.addr = 12'(16 + k); u_r0.d = 32'(k);
      @(negedge clk);
      check("gap_gnt", 64'(u_r0.gnt), 64'd1);
      if (ce) nce++;
    end
    step(); u_r0.ce = 0; u_r0.req = 0;
    @(negedge clk);
    check("gap_nce", 64'(nce), 64'd3);
    check("gap_done", 64'({u_r0.done, ce}), 64'b10);

    // Abort: r1 len 8 drops req after 3 beats; r0 pending behind it
    step(); u_r1.req = 1; u_r1.len = 13'd8; u_r0.req = 1; u_r0.len = 13'd0;
    for (int i = 0; i < 3; i++) begin
      step(); u_r1.ce = 1; u_r1.we = 0; u_r1.addr = 12'(i);
      @(negedge clk);
      check("ab_beat", 64'({u_r1.gnt, ce}), 64'b11);
    end
    step(); u_r1.req = 0;
    @(negedge clk);
    check("ab_drop_ce", 64'({u_r1.gnt, ce}), 64'b10);
    step(); u_r1.ce = 0;
    @(negedge clk);
    check("ab_done", 64'({u_r1.done, u_r0.gnt}), 64'b10);
    step();
    @(negedge clk);
    check("ab_idle", 64'({busy, u_r0.gnt}), 64'd0);
    step();
    @(negedge clk);
    check("ab_next_gnt", 64'(u_r0.gnt), 64'd1);
    step(); u_r0.req = 0;
    @(negedge clk);
    check("ab_r0_done", 64'(u_r0.done), 64'd1);
    step();

    // Reset during beat 2 of an r0 len 6 burst
    step(); u_r0.req = 1; u_r0.len = 13'd6;
    step(); u_r0.ce = 1; u_r0.we = 1; u_r0.addr = 12'd30;
    step(); u_r0.addr = 12'd31;
    #1;
    check("mr_pre_ce", 64'({u_r0.gnt, ce}), 64'b11);
    reset_n = 1'b0;
    #1;
    check("mr_ce", 64'({ce, we, u_r0.gnt, busy}), 64'd0);
    @(negedge clk);
    check("mr_done", 64'({u_r0.done, u_r1.done}), 64'd0);
    step(); u_r0.ce = 0;
    @(negedge clk);
    reset_n = 1'b1;
    u_r1.req = 1; u_r1.len = 13'd1;
    step();
    @(negedge clk);
    check("mr_first", 64'({u_r0.gnt, u_r1.gnt, u_r0.done}), 64'b100);
    step(); idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
